// File: rtl/img_pkg.sv
// Shared definitions for the image loader: FSM encoding, default sizing and
// the DRAM request record passed to the port mux.
package img_pkg;

  localparam logic [15:0] IN_LEN_DEF   = 16'd256;
  localparam logic [15:0] OUT_BASE_DEF = 16'h8000;
  localparam logic [15:0] OUT_LEN_DEF  = 16'd64;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] RUN       = 3'd2;
  localparam logic [2:0] DUMP_RD   = 3'd3;
  localparam logic [2:0] DUMP_WAIT = 3'd4;
  localparam logic [2:0] DUMP_OUT  = 3'd5;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LOAD,
    SEL_PROC,
    SEL_DUMP
  } port_sel_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
  } mem_req_t;

endpackage

// File: rtl/mem_port_mux.sv
// Combinational DRAM port selection between the loader, Processor and dump
// paths; unselected paths see an idle, zeroed port.
module mem_port_mux
  import img_pkg::*;
(
  input  port_sel_e   sel,
  input  mem_req_t    load_req,
  input  mem_req_t    proc_req,
  input  mem_req_t    dump_req,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic [7:0]  proc_din
);

  mem_req_t req;

  always_comb begin
    req      = '0;
    proc_din = '0;
    case (sel)
      SEL_LOAD: req = load_req;
      SEL_PROC: begin
        req      = proc_req;
        proc_din = mem_rdata;
      end
      SEL_DUMP: req = dump_req;
      default:  req = '0;
    endcase
  end

  assign mem_addr  = req.addr;
  assign mem_wdata = req.wdata;
  assign mem_we    = req.we;

endmodule

// File: rtl/img_loader.sv
// Streams an image into DRAM, hands DRAM to the Processor until it finishes,
// then streams the result region out one byte per three cycles.
module img_loader
  import img_pkg::*;
#(
  parameter logic [15:0] IN_LEN   = IN_LEN_DEF,
  parameter logic [15:0] OUT_BASE = OUT_BASE_DEF,
  parameter logic [15:0] OUT_LEN  = OUT_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [7:0]  m_data,
  input  logic        m_ready,
  output logic        proc_enable,
  input  logic        proc_finish,
  input  logic [15:0] proc_addr,
  input  logic [7:0]  proc_dout,
  input  logic        proc_write,
  input  logic        proc_read,
  output logic [7:0]  proc_din,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        done
);

  logic [2:0]  state;
  logic [15:0] cnt, k;
  logic        accept, last_out;
  port_sel_e   sel;
  mem_req_t    load_req, proc_req, dump_req;

  // Read data is simply returned one cycle later; the strobe carries no extra meaning.
  logic unused_read;
  assign unused_read = proc_read;

  // Gating with rst_n keeps the write strobe low while reset is held.
  assign s_ready     = rst_n & ((state == IDLE) | (state == LOAD));
  assign accept      = s_valid & s_ready;
  assign proc_enable = (state == RUN);
  assign m_valid     = (state == DUMP_OUT);
  assign last_out    = (k == OUT_LEN - 16'd1);
  assign done        = m_valid & m_ready & last_out;

  assign load_req = '{addr: accept ? cnt : 16'd0, wdata: s_data, we: accept};
  assign proc_req = '{addr: proc_addr, wdata: proc_dout, we: proc_write};
  assign dump_req = '{addr: OUT_BASE + k, wdata: 8'd0, we: 1'b0};

  always_comb begin
    sel = SEL_NONE;
    case (state)
      IDLE, LOAD: sel = SEL_LOAD;
      RUN:        sel = SEL_PROC;
      DUMP_RD:    sel = SEL_DUMP;
      default:    sel = SEL_NONE;
    endcase
  end

  mem_port_mux u_mux (
    .sel       (sel),
    .load_req  (load_req),
    .proc_req  (proc_req),
    .dump_req  (dump_req),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .proc_din  (proc_din)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      k      <= '0;
      m_data <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt   <= 16'd1;
          state <= (IN_LEN == 16'd1) ? RUN : LOAD;
        end
        LOAD: if (accept) begin
          cnt <= cnt + 16'd1;
          if (cnt == IN_LEN - 16'd1) state <= RUN;
        end
        RUN: if (proc_finish) state <= DUMP_RD;
        DUMP_RD: state <= DUMP_WAIT;
        DUMP_WAIT: begin
          m_data <= mem_rdata;
          state  <= DUMP_OUT;
        end
        DUMP_OUT: if (m_ready) begin
          if (last_out) begin
            state <= IDLE;
            cnt   <= '0;
            k     <= '0;
          end else begin
            k     <= k + 16'd1;
            state <= DUMP_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_loader.sv
// Scoreboard bench for img_loader: stimulus pushes expected DRAM writes and
// result bytes; a negedge monitor pops and compares as the DUT presents them.
module tb_img_loader;

  localparam logic [15:0] IN_LEN   = 16'd16;
  localparam logic [15:0] OUT_BASE = 16'h0100;
  localparam logic [15:0] OUT_LEN  = 16'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [7:0]  s_data, m_data;
  logic        proc_enable, proc_finish, proc_write, proc_read;
  logic [15:0] proc_addr, mem_addr;
  logic [7:0]  proc_dout, proc_din, mem_wdata, mem_rdata;
  logic        mem_we, done;

  logic [7:0]  dram [0:65535];
  logic [23:0] wr_q [$];
  logic [7:0]  out_q [$];
  logic [23:0] wr_e;
  logic [7:0]  out_e;
  int checks = 0, passes = 0, cyc = 0, done_cnt = 0;

  img_loader #(.IN_LEN(IN_LEN), .OUT_BASE(OUT_BASE), .OUT_LEN(OUT_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .proc_enable(proc_enable), .proc_finish(proc_finish), .proc_addr(proc_addr),
    .proc_dout(proc_dout), .proc_write(proc_write), .proc_read(proc_read),
    .proc_din(proc_din), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read DRAM model
  always @(posedge clk) begin
    if (mem_we) dram[mem_addr] <= mem_wdata;
    mem_rdata <= dram[mem_addr];
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (wr_q.size() == 0) fail("unexpected_write");
        else begin
          wr_e = wr_q.pop_front();
          chk("wr_addr", {16'd0, mem_addr}, {16'd0, wr_e[23:8]});
          chk("wr_data", {24'd0, mem_wdata}, {24'd0, wr_e[7:0]});
        end
      end
      if (m_valid && m_ready) begin
        if (out_q.size() == 0) fail("unexpected_output");
        else begin
          out_e = out_q.pop_front();
          chk("m_data", {24'd0, m_data}, {24'd0, out_e});
          chk("done", {31'd0, done}, (out_q.size() == 0) ? 32'd1 : 32'd0);
        end
      end else if (done) fail("stray_done");
      if (done) done_cnt++;
    end
  end

  task automatic do_load(input logic [7:0] base, input int gap_after, input bit fin_in_gap);
    for (int i = 0; i < int'(IN_LEN); i++) begin
      s_valid = 1'b1;
      s_data  = base + 8'(i);
      wr_q.push_back({16'(i), s_data});
      @(posedge clk); #1;
      if (i == gap_after) begin
        s_valid     = 1'b0;
        proc_finish = fin_in_gap;
        repeat (5) begin
          @(posedge clk); #1;
          chk("gap_we", {31'd0, mem_we}, 32'd0);
          chk("gap_pe", {31'd0, proc_enable}, 32'd0);
        end
        proc_finish = 1'b0;
      end
    end
    s_valid = 1'b0;
    chk("run_pe", {31'd0, proc_enable}, 32'd1);
    chk("run_srdy", {31'd0, s_ready}, 32'd0);
  endtask

  task automatic do_proc(input logic [31:0] bytes, input logic [7:0] base);
    for (int j = 0; j < 4; j++) begin
      proc_addr  = OUT_BASE + 16'(j);
      proc_dout  = bytes[8*j +: 8];
      proc_write = 1'b1;
      wr_q.push_back({proc_addr, proc_dout});
      @(posedge clk); #1;
    end
    proc_write = 1'b0;
    proc_addr  = 16'd5;
    proc_read  = 1'b1;
    @(posedge clk); #1;
    chk("proc_din", {24'd0, proc_din}, {24'd0, base + 8'd5});
    proc_read   = 1'b0;
    proc_finish = 1'b1;
    @(posedge clk); #1;
    proc_finish = 1'b0;
    chk("fin_pe", {31'd0, proc_enable}, 32'd0);
  endtask

  task automatic do_dump(input logic [31:0] bytes, input int stall_at);
    int t_prev = 0;
    int n;
    logic [7:0] held;
    for (int j = 0; j < 4; j++) out_q.push_back(bytes[8*j +: 8]);
    for (int j = 0; j < 4; j++) begin
      n = 0;
      while (!m_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (!m_valid) begin
        fail("m_valid_timeout");
        return;
      end
      if (stall_at < 0 && j > 0) chk("thruput", cyc - t_prev, 32'd3);
      t_prev = cyc;
      if (j == stall_at) begin
        m_ready = 1'b0;
        held    = m_data;
        repeat (10) begin
          @(posedge clk); #1;
          chk("stall_mv", {31'd0, m_valid}, 32'd1);
          chk("stall_md", {24'd0, m_data}, {24'd0, held});
        end
        m_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("idle_srdy", {31'd0, s_ready}, 32'd1);
    chk("idle_mv", {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    proc_finish = 1'b0; proc_addr = '0; proc_dout = '0; proc_write = 1'b0; proc_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_srdy", {31'd0, s_ready}, 32'd0);
    chk("rst_mv", {31'd0, m_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pe", {31'd0, proc_enable}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_md", {24'd0, m_data}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_srdy0", {31'd0, s_ready}, 32'd1);

    // Load with a 5-cycle gap after byte 7 and a spurious finish in it
    do_load(8'h00, 7, 1'b1);
    do_proc(32'hDECDBCAB, 8'h00);
    do_dump(32'hDECDBCAB, -1);

    // Second frame: stall the sink on result byte 2
    do_load(8'h20, -1, 1'b0);
    do_proc(32'h44332211, 8'h20);
    do_dump(32'h44332211, 2);

    // Abort mid-load, then reload from address 0
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 8'hC0 + 8'(i);
      wr_q.push_back({16'(i), s_data});
      @(posedge clk); #1;
    end
    s_data = 8'hEE;
    rst_n  = 1'b0;
    #1;
    chk("arst_we", {31'd0, mem_we}, 32'd0);
    chk("arst_srdy", {31'd0, s_ready}, 32'd0);
    chk("arst_addr", {16'd0, mem_addr}, 32'd0);
    chk("arst_pe", {31'd0, proc_enable}, 32'd0);
    chk("arst_mv", {31'd0, m_valid}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_md", {24'd0, m_data}, 32'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    rst_n   = 1'b1;
    do_load(8'h50, -1, 1'b0);

    @(posedge clk); #1;
    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("out_q_empty", out_q.size(), 32'd0);
    chk("done_pulses", done_cnt, 32'd2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/img_loader.md
IMG_LOADER -- requirements
Module: img_loader

Interface
REQ-001 Parameter IN_LEN, default 16'd256: number of input image bytes loaded into DRAM, legal range 1..65535.
REQ-002 Parameter OUT_BASE, default 16'h8000: first DRAM address of the downsampled result region.
REQ-003 Parameter OUT_LEN, default 16'd64: number of result bytes streamed out, legal range 1..65535.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  an input image byte is present.
- s_data  in  8  input image byte.
- s_ready  out  1  the block accepts s_data this cycle.
- m_valid  out  1  a result byte is present on m_data.
- m_data  out  8  result byte.
- m_ready  in  1  the sink accepts m_data this cycle.
- proc_enable  out  1  Processor run enable.
- proc_finish  in  1  Processor finish flag.
- proc_addr  in  16  Processor DRAM address.
- proc_dout  in  8  Processor write data.
- proc_write  in  1  Processor write strobe.
- proc_read  in  1  Processor read strobe.
- proc_din  out  8  read data returned to the Processor.
- mem_addr  out  16  DRAM address.
- mem_wdata  out  8  DRAM write data.
- mem_we  out  1  DRAM write enable.
- mem_rdata  in  8  DRAM read data, valid one cycle after mem_addr is presented (synchronous read).
- done  out  1  one-cycle pulse when the last result byte is accepted.

Function
REQ-005 The block SHALL implement an FSM with states IDLE, LOAD, RUN, DUMP_RD, DUMP_WAIT and DUMP_OUT.
REQ-006 IDLE SHALL hold s_ready=1 and, on s_valid=1, write s_data to address 0 and enter LOAD with the byte counter set to 1, or enter RUN directly if IN_LEN==1.
REQ-007 LOAD SHALL hold s_ready=1 and, on each s_valid&s_ready, drive mem_addr=cnt, mem_wdata=s_data, mem_we=1 in the same cycle and increment cnt.
REQ-008 LOAD SHALL enter RUN on the cycle after the byte at address IN_LEN-1 is accepted; s_valid low stalls LOAD indefinitely with no write.
REQ-009 In all states other than IDLE and LOAD, s_ready SHALL be 0 and s_valid SHALL be ignored.
REQ-010 RUN SHALL:
- hold proc_enable=1;
- connect the DRAM port to the Processor: mem_addr=proc_addr, mem_wdata=proc_dout, mem_we=proc_write, proc_din=mem_rdata;
- leave all DRAM outputs undriven by the Processor in every other state, with proc_enable=0.
REQ-011 RUN SHALL enter DUMP_RD on the first cycle proc_finish=1; proc_finish in any other state SHALL be ignored.
REQ-012 DUMP_RD SHALL drive mem_addr=OUT_BASE+k (16-bit wrap-around), mem_we=0, then enter DUMP_WAIT.
REQ-013 DUMP_WAIT SHALL capture mem_rdata into the m_data register, then enter DUMP_OUT.
REQ-014 DUMP_OUT SHALL hold m_valid=1 with m_data stable until m_ready=1, then:
- increment k;
- return to DUMP_RD if k<OUT_LEN;
- otherwise pulse done and enter IDLE.
REQ-015 Result throughput SHALL be one byte per 3 cycles when m_ready is held high.
REQ-016 Counters cnt and k SHALL be 16 bits and cleared on entry to IDLE.
REQ-017 When not otherwise specified, mem_we SHALL be 0, mem_addr SHALL be 0 and m_valid SHALL be 0.

Reset
REQ-018 rst_n=0 SHALL asynchronously force IDLE, cnt=0, k=0, m_data=0, m_valid=0, done=0, proc_enable=0 and mem_we=0, regardless of the current state, including mid-LOAD, mid-RUN or a stalled DUMP_OUT.
REQ-019 After rst_n deasserts, the first action SHALL be a fresh load starting at address 0.

Structure
REQ-020 The FSM state encoding and the default parameter values SHALL live in the shared package img_pkg.
REQ-021 A single sub-module, mem_port_mux, SHALL implement the combinational DRAM port selection between loader, Processor and dump paths.

Verification (IN_LEN=16, OUT_BASE=16'h0100, OUT_LEN=4)
REQ-022 Stream bytes 0x00..0x0F with s_valid held high -> 16 consecutive writes to addresses 0..15, then proc_enable=1 on the following cycle.
REQ-023 Drop s_valid low for 5 cycles after byte 7 -> no mem_we during the gap and no address skipped.
REQ-024 In RUN, Processor writes 0xAB to 0x0100 and then pulses proc_finish -> proc_enable=0 on the next cycle and the first m_data=0xAB.
REQ-025 Preload 0x0100..0x0103 with 0x11,0x22,0x33,0x44 and hold m_ready low for 10 cycles at byte 2 -> output sequence 11,22,33,44 with m_data stable during the stall and done pulsing once after 0x44.
REQ-026 Assert rst_n=0 mid-LOAD after byte 9 -> all outputs at reset values immediately, and a new stream writes starting at address 0.
REQ-027 Assert proc_finish during LOAD -> no state change and no dump.
